// File: rtl/fp_div_result_stage_pkg.sv
// Shared IEEE-754 class/exception flag layout and buffer occupancy encoding for the divider
// result stage.
package fp_div_result_stage_pkg;

  // Result class bits (one-hot qFlags)
  localparam int NTYPES    = 6;
  localparam int SNAN      = 5;
  localparam int QNAN      = 4;
  localparam int INFINITY  = 3;
  localparam int ZERO      = 2;
  localparam int NORMAL    = 1;
  localparam int SUBNORMAL = 0;

  // Exception bits
  localparam int NEXCEPTIONS  = 5;
  localparam int INVALID      = 4;
  localparam int DIVIDEBYZERO = 3;
  localparam int OVERFLOW     = 2;
  localparam int UNDERFLOW    = 1;
  localparam int INEXACT      = 0;

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StTwo
  } occ_e;

endpackage

// File: rtl/fp_skid_buf.sv
// Generic 2-entry valid/ready buffer; in_ready and all out_* come straight from flops so no
// combinational path crosses it.
module fp_skid_buf
  import fp_div_result_stage_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  occ_e         state;
  logic [W-1:0] skid_data;
  logic         accept;
  logic         deliver;

  assign accept  = in_valid & in_ready;
  assign deliver = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StEmpty;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_data <= '0;
    end else begin
      case (state)
        StEmpty: begin
          if (accept) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= StOne;
          end
        end
        StOne: begin
          if (accept && deliver) begin
            out_data <= in_data;
          end else if (accept) begin
            skid_data <= in_data;
            in_ready  <= 1'b0;
            state     <= StTwo;
          end else if (deliver) begin
            out_valid <= 1'b0;
            state     <= StEmpty;
          end
        end
        StTwo: begin
          // Older entry sits in main, so the skid entry is next in line.
          if (deliver) begin
            out_data <= skid_data;
            in_ready <= 1'b1;
            state    <= StOne;
          end
        end
        default: state <= StEmpty;
      endcase
    end
  end

endmodule

// File: rtl/fp_div_result_stage.sv
// Registered result stage after the combinational divider: skid-buffered {q, qFlags, exception},
// sticky exception status with clear, and a saturating completed-operation counter.
module fp_div_result_stage
  import fp_div_result_stage_pkg::*;
#(
  parameter int NEXP = 5,
  parameter int NSIG = 10,
  parameter int CNTW = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NEXP+NSIG:0]     in_q,
  input  logic [NTYPES-1:0]      in_qflags,
  input  logic [NEXCEPTIONS-1:0] in_exc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NEXP+NSIG:0]     out_q,
  output logic [NTYPES-1:0]      out_qflags,
  output logic [NEXCEPTIONS-1:0] out_exc,
  input  logic                   status_clr,
  output logic [NEXCEPTIONS-1:0] status,
  output logic [CNTW-1:0]        op_count
);

  localparam int unsigned PW = NEXP + NSIG + 1 + NTYPES + NEXCEPTIONS;

  logic [PW-1:0]          in_payload;
  logic [PW-1:0]          out_payload;
  logic                   accept;
  logic [NEXCEPTIONS-1:0] status_d;

  assign in_payload = {in_q, in_qflags, in_exc};
  assign {out_q, out_qflags, out_exc} = out_payload;
  assign accept = in_valid & in_ready;

  fp_skid_buf #(
    .W (PW)
  ) u_skid_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  // New exceptions are ORed in after the clear, so a same-cycle set survives.
  always_comb begin
    status_d = status & ~{NEXCEPTIONS{status_clr}};
    if (accept) status_d = status_d | in_exc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status   <= '0;
      op_count <= '0;
    end else begin
      status <= status_d;
      if (accept && (op_count != {CNTW{1'b1}})) op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_div_result_stage.sv
// Randomized plus directed bench for fp_div_result_stage against a queue-based reference model.
module tb_fp_div_result_stage;
  import fp_div_result_stage_pkg::*;

  localparam int NEXP = 5;
  localparam int NSIG = 10;
  localparam int CNTW = 4;
  localparam int QW   = NEXP + NSIG + 1;
  localparam int PW   = QW + NTYPES + NEXCEPTIONS;
  localparam int CMAX = (1 << CNTW) - 1;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [QW-1:0]          in_q = '0;
  logic [NTYPES-1:0]      in_qflags = '0;
  logic [NEXCEPTIONS-1:0] in_exc = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [QW-1:0]          out_q;
  logic [NTYPES-1:0]      out_qflags;
  logic [NEXCEPTIONS-1:0] out_exc;
  logic                   status_clr = 1'b0;
  logic [NEXCEPTIONS-1:0] status;
  logic [CNTW-1:0]        op_count;

  always #5 clk = ~clk;

  fp_div_result_stage #(
    .NEXP (NEXP),
    .NSIG (NSIG),
    .CNTW (CNTW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_q       (in_q),
    .in_qflags  (in_qflags),
    .in_exc     (in_exc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_q      (out_q),
    .out_qflags (out_qflags),
    .out_exc    (out_exc),
    .status_clr (status_clr),
    .status     (status),
    .op_count   (op_count)
  );

  // Reference model: FIFO of pending results (capacity 2), sticky flags, saturating count.
  logic [PW-1:0]          mq[$];
  logic [NEXCEPTIONS-1:0] m_status = '0;
  int                     m_count  = 0;
  int                     n_cmp    = 0;
  int                     n_fail   = 0;
  bit                     checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_status = '0;
    m_count  = 0;
  endtask

  task automatic model_step();
    bit acc;
    bit del;
    if (rst) return;
    acc = in_valid && (mq.size() < 2);
    del = out_ready && (mq.size() > 0);
    if (del) mq.delete(0);
    if (acc) mq.push_back({in_q, in_qflags, in_exc});
    m_status = (status_clr ? '0 : m_status) | (acc ? in_exc : '0);
    if (acc && m_count < CMAX) m_count++;
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
      chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) chk("out_payload", 32'({out_q, out_qflags, out_exc}), 32'(mq[0]));
      chk("status", 32'(status), 32'(m_status));
      chk("op_count", 32'(op_count), 32'(m_count));
    end
  end

  // Drive one cycle's inputs, advance the model at the edge, return at the next negedge.
  task automatic cycle(input logic v, input logic [QW-1:0] q, input logic [NTYPES-1:0] f,
                       input logic [NEXCEPTIONS-1:0] e, input logic ordy, input logic clr);
    in_valid   = v;
    in_q       = q;
    in_qflags  = f;
    in_exc     = e;
    out_ready  = ordy;
    status_clr = clr;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_q", 32'(out_q), 32'h0);
    chk("rst_out_qflags", 32'(out_qflags), 32'h0);
    chk("rst_out_exc", 32'(out_exc), 32'h0);
    chk("rst_status", 32'(status), 32'h0);
    chk("rst_op_count", 32'(op_count), 32'h0);
    rst = 1'b0;
    checking = 1'b1;

    // 1/3: quotient 3555, NORMAL, INEXACT
    cycle(1'b1, 16'h3555, 6'h02, 5'h01, 1'b1, 1'b0);
    chk("t1_out_valid", 32'(out_valid), 32'h1);
    chk("t1_out_q", 32'(out_q), 32'h3555);
    chk("t1_qflags", 32'(out_qflags), 32'h02);
    chk("t1_exc", 32'(out_exc), 32'h01);
    chk("t1_status", 32'(status), 32'h01);
    cycle(1'b0, '0, '0, '0, 1'b1, 1'b1);
    chk("clr_alone", 32'(status), 32'h00);

    // 1/0 -> +inf DIVIDEBYZERO; 0/0 -> qNaN INVALID
    cycle(1'b1, 16'h7C00, 6'h08, 5'h08, 1'b1, 1'b0);
    chk("t2_inf_q", 32'(out_q), 32'h7C00);
    chk("t2_inf_flags", 32'(out_qflags), 32'h08);
    cycle(1'b1, 16'h7E00, 6'h10, 5'h10, 1'b1, 1'b0);
    chk("t2_nan_q", 32'(out_q), 32'h7E00);
    chk("t2_nan_exc", 32'(out_exc), 32'h10);
    chk("t2_status", 32'(status), 32'h18);

    // Clear and set in the same cycle: set wins
    cycle(1'b1, 16'h3555, 6'h02, 5'h01, 1'b1, 1'b1);
    chk("t4_clr_set", 32'(status), 32'h01);
    cycle(1'b0, '0, '0, '0, 1'b1, 1'b1);
    chk("t4_clr", 32'(status), 32'h00);

    // Stalled consumer: A, B accepted, C refused until space frees
    cycle(1'b1, 16'h1111, 6'h02, 5'h00, 1'b0, 1'b0);
    chk("t3_rdy_after_a", 32'(in_ready), 32'h1);
    cycle(1'b1, 16'h2222, 6'h02, 5'h00, 1'b0, 1'b0);
    chk("t3_rdy_full", 32'(in_ready), 32'h0);
    chk("t3_head_a", 32'(out_q), 32'h1111);
    cycle(1'b1, 16'h3333, 6'h02, 5'h00, 1'b0, 1'b0);
    chk("t3_hold_a", 32'(out_q), 32'h1111);
    cycle(1'b1, 16'h3333, 6'h02, 5'h00, 1'b1, 1'b0);
    chk("t3_head_b", 32'(out_q), 32'h2222);
    cycle(1'b1, 16'h3333, 6'h02, 5'h00, 1'b1, 1'b0);
    chk("t3_head_c", 32'(out_q), 32'h3333);
    cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);
    chk("t3_drained", 32'(out_valid), 32'h0);

    // Asynchronous reset with two entries held
    cycle(1'b1, 16'h4444, 6'h02, 5'h01, 1'b0, 1'b0);
    cycle(1'b1, 16'h5555, 6'h02, 5'h04, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    model_reset();
    #1;
    chk("t6_out_valid", 32'(out_valid), 32'h0);
    chk("t6_in_ready", 32'(in_ready), 32'h1);
    chk("t6_status", 32'(status), 32'h0);
    chk("t6_op_count", 32'(op_count), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Counter saturation
    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, 16'(i), 6'h02, 5'h00, 1'b1, 1'b0);
      if (i == 13) chk("t5_count_14", 32'(op_count), 32'hE);
      if (i == 14) chk("t5_count_15", 32'(op_count), 32'hF);
    end
    chk("t5_count_sat", 32'(op_count), 32'hF);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 16'($urandom), 6'(1 << $urandom_range(0, 5)),
            5'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
      if (i == 1500) begin
        in_valid = 1'b0;
        #1 rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
      end
    end

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
